meter_display_driver: RTL and testbench

// - Display end of the parking-meter count path: consumes 16-bit binary seconds-remaining, drives 4-digit 7-seg.
// - Sequential binary->BCD conversion (shift-add-3), digit multiplexing, and meter blink rules (expired / low time).
// - Sits between the meter counter (In_Bin16 source) and the board anodes/segments; purely a reader, never back-pressures.

---
 rtl/meter_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/meter_display_driver.sv | 113 +++++++++++
 tb/tb_meter_display_driver.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
`default_nettype none
//==============================================================================
// meter_pkg: shared 7-segment patterns, converter states and meter thresholds
// Rev 1.0
//==============================================================================
package meter_pkg;

  localparam int LOW_THRESH = 180;
  localparam int MAX_SHOW   = 9999;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
//==============================================================================
// bin2bcd_seq: sequential shift-add-3 binary to 4-digit BCD converter, one bit per cycle
// Rev 1.0
//==============================================================================
module bin2bcd_seq #(
  parameter int MAX_SHOW = meter_pkg::MAX_SHOW
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bcd_o,
  output logic [15:0] val_o,
  output logic [15:0] sampled_o
);
  import meter_pkg::*;

  conv_state_t state_q;
  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] val_q;
  logic [15:0] sampled_q;
  logic [3:0]  cnt_q;

  logic [15:0] clamp_d;
  logic [15:0] bcd_adj_d;
  logic [31:0] shift_d;

  assign clamp_d = (bin_i > 16'(MAX_SHOW)) ? 16'(MAX_SHOW) : bin_i;

  always_comb begin
    bcd_adj_d = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  assign shift_d = {bcd_adj_d, bin_q} << 1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      val_q     <= '0;
      sampled_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          bin_q     <= clamp_d;
          val_q     <= clamp_d;
          bcd_q     <= '0;
          sampled_q <= bin_i;
          cnt_q     <= '0;
          state_q   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_q <= shift_d[31:16];
          bin_q <= shift_d[15:0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_COMMIT);
  assign bcd_o     = bcd_q;
  assign val_o     = val_q;
  assign sampled_o = sampled_q;

endmodule
`default_nettype wire

// File: rtl/meter_display_driver.sv
`default_nettype none
//==============================================================================
// meter_display_driver: 4-digit 7-seg scan of seconds remaining with expiry/low-time blink
// Rev 1.0
//==============================================================================
module meter_display_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_HALF  = 50_000_000,
  parameter int LOW_THRESH  = meter_pkg::LOW_THRESH,
  parameter int MAX_SHOW    = meter_pkg::MAX_SHOW
) (
  input  logic        SYS_CLK,
  input  logic        RESET,
  input  logic [15:0] In_Bin16,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);
  import meter_pkg::*;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [RW-1:0] refresh_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] blink_q;
  logic          fast_q;
  logic          slow_q;
  logic          half_q;
  logic [15:0]   bcd_q;
  logic [15:0]   val_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  logic          conv_busy;
  logic          conv_done;
  logic [15:0]   conv_bcd;
  logic [15:0]   conv_val;
  logic [15:0]   conv_sampled;
  logic          conv_start;
  logic          lit_d;
  logic [3:0]    nib_d;

  assign conv_start = !conv_busy && (In_Bin16 != conv_sampled);

  bin2bcd_seq #(
    .MAX_SHOW (MAX_SHOW)
  ) u_bin2bcd (
    .clk_i     (SYS_CLK),
    .rst_ni    (RESET),
    .start_i   (conv_start),
    .bin_i     (In_Bin16),
    .busy_o    (conv_busy),
    .done_o    (conv_done),
    .bcd_o     (conv_bcd),
    .val_o     (conv_val),
    .sampled_o (conv_sampled)
  );

  always_comb begin
    lit_d = 1'b1;
    if (val_q == '0) lit_d = fast_q;
    else if (val_q < 16'(LOW_THRESH)) lit_d = slow_q;
  end

  assign nib_d = bcd_q[{idx_q, 2'b00} +: 4];

  always_ff @(posedge SYS_CLK) begin
    if (!RESET) begin
      refresh_q <= '0;
      idx_q     <= '0;
      blink_q   <= '0;
      fast_q    <= 1'b1;
      slow_q    <= 1'b1;
      half_q    <= 1'b0;
      bcd_q     <= '0;
      val_q     <= '0;
      an_q      <= 4'hF;
      seg_q     <= SEG_BLANK;
    end else begin
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        idx_q     <= idx_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end

      // Slow phase flips on every second fast-phase flip
      if (blink_q == BW'(BLINK_HALF - 1)) begin
        blink_q <= '0;
        fast_q  <= ~fast_q;
        half_q  <= ~half_q;
        if (half_q) slow_q <= ~slow_q;
      end else begin
        blink_q <= blink_q + BW'(1);
      end

      if (conv_done) begin
        bcd_q <= conv_bcd;
        val_q <= conv_val;
      end

      an_q  <= lit_d ? ~(4'b0001 << idx_q) : 4'hF;
      seg_q <= lit_d ? seg_decode(nib_d) : SEG_BLANK;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_meter_display_driver.sv
`default_nettype none
//==============================================================================
// tb_meter_display_driver: randomized and directed checks against a behavioural display model
// Rev 1.0
//==============================================================================
module tb_meter_display_driver;

  localparam int RD = 4;
  localparam int BH = 8;
  localparam int LT = 180;
  localparam int MS = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bin = 16'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  meter_display_driver #(
    .REFRESH_DIV (RD),
    .BLINK_HALF  (BH),
    .LOW_THRESH  (LT),
    .MAX_SHOW    (MS)
  ) dut (
    .SYS_CLK  (clk),
    .RESET    (rst_n),
    .In_Bin16 (bin),
    .AN       (an),
    .SEG      (seg),
    .DP       (dp)
  );

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Display expected after an edge, from cycles-since-reset k and committed value v before it
  function automatic logic [10:0] disp_ref(input int k, input int v);
    int idx;
    int dig;
    bit lit;
    logic [3:0] a;
    idx = (k / RD) % 4;
    dig = v;
    for (int i = 0; i < idx; i++) dig = dig / 10;
    dig = dig % 10;
    if (v == 0) lit = ((k / BH) % 2) == 0;
    else if (v < LT) lit = ((k / (2 * BH)) % 2) == 0;
    else lit = 1'b1;
    if (!lit) return {4'hF, 7'h7F};
    a = 4'hF;
    a[idx] = 1'b0;
    return {a, seg_ref(dig)};
  endfunction

  int         cyc;
  int         m_cnt;
  int         m_last;
  int         m_pend;
  int         m_val;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc     <= 0;
      m_cnt   <= 0;
      m_last  <= 0;
      m_pend  <= 0;
      m_val   <= 0;
      exp_an  <= 4'hF;
      exp_seg <= 7'h7F;
    end else begin
      cyc <= cyc + 1;
      {exp_an, exp_seg} <= disp_ref(cyc, m_val);
      // A new value is noticed only while no conversion is running; it lands 18 edges later
      if (m_cnt == 0) begin
        if (int'(bin) != m_last) m_cnt <= 1;
      end else begin
        if (m_cnt == 1) begin
          m_last <= int'(bin);
          m_pend <= (int'(bin) > MS) ? MS : int'(bin);
        end
        if (m_cnt == 18) begin
          m_val <= m_pend;
          m_cnt <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic test_reset();
    int lit_cnt;
    rst_n = 1'b0;
    bin   = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_dark: AN=%h SEG=%h DP=%b, want AN=f SEG=7f DP=1", an, seg, dp);
      end
    end
    rst_n   = 1'b1;
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL zero_blink: AN=%h SEG=%h got, want AN=%h SEG=%h", an, seg, exp_an, exp_seg);
      end
      if (an !== 4'hF) lit_cnt++;
    end
    checks++;
    if (lit_cnt != 16) begin
      errors++;
      $display("FAIL zero_duty: lit cycles=%0d in 32, want 16", lit_cnt);
    end
  endtask

  task automatic test_steady_1234();
    bin = 16'd1234;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL conv_1234: AN=%h SEG=%h got, want AN=%h SEG=%h", an, seg, exp_an, exp_seg);
      end
    end
    for (int i = 0; i < 32; i++) begin
      logic [6:0] want;
      @(negedge clk);
      case (an)
        4'hE:    want = 7'h19;
        4'hD:    want = 7'h30;
        4'hB:    want = 7'h24;
        4'h7:    want = 7'h79;
        default: want = 7'h7F;
      endcase
      checks++;
      if (an === 4'hF || seg !== want) begin
        errors++;
        $display("FAIL digits_1234: AN=%h SEG=%h, want lit digit with SEG=%h", an, seg, want);
      end
    end
  endtask

  task automatic test_low_blink();
    logic [15:0] vals [3];
    vals[0] = 16'd150;
    vals[1] = 16'd179;
    vals[2] = 16'd180;
    for (int v = 0; v < 3; v++) begin
      bin = vals[v];
      for (int i = 0; i < 70; i++) begin
        @(negedge clk);
        checks++;
        if (an !== exp_an || seg !== exp_seg) begin
          errors++;
          $display("FAIL low_blink(%0d): AN=%h SEG=%h got, want AN=%h SEG=%h", vals[v], an, seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] vals [2];
    vals[0] = 16'd12000;
    vals[1] = 16'd65535;
    for (int v = 0; v < 2; v++) begin
      bin = vals[v];
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        checks++;
        if (an !== exp_an || seg !== exp_seg) begin
          errors++;
          $display("FAIL clamp(%0d): AN=%h SEG=%h got, want AN=%h SEG=%h", vals[v], an, seg, exp_an, exp_seg);
        end
      end
      checks++;
      if (an === 4'hF || seg !== 7'h10) begin
        errors++;
        $display("FAIL clamp_9s(%0d): AN=%h SEG=%h, want lit SEG=10", vals[v], an, seg);
      end
    end
  endtask

  task automatic test_change_mid_shift();
    bin = 16'd205;
    for (int i = 0; i < 6; i++) @(negedge clk);
    bin = 16'd10;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL mid_shift: AN=%h SEG=%h got, want AN=%h SEG=%h", an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    bin = 16'd550;
    for (int i = 0; i < 7; i++) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || seg !== 7'h7F) begin
        errors++;
        $display("FAIL reset_mid_dark: AN=%h SEG=%h, want AN=f SEG=7f", an, seg);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL reset_mid: AN=%h SEG=%h got, want AN=%h SEG=%h", an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       bin = 16'd0;
        1:       bin = 16'($urandom_range(1, LT - 1));
        2:       bin = 16'($urandom_range(LT, MS));
        default: bin = 16'($urandom_range(0, 65535));
      endcase
      hold = int'($urandom_range(3, 60));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
          errors++;
          $display("FAIL random(%0d): AN=%h SEG=%h got, want AN=%h SEG=%h", bin, an, seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady_1234();
    test_low_blink();
    test_clamp();
    test_change_mid_shift();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
